bicubic_feeder: RTL and testbench

BICUBIC_FEEDER -- requirements
Module: bicubic_feeder

---
 rtl/bicubic_feeder.sv | 276 +++++++++++++++++++++++++++
 tb/tb_bicubic_feeder.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bicubic_feeder.sv
// Sequences one bicubic window: four horizontal row passes through an external
// engine, then one vertical pass over the row results, and reports the pixel.
module bicubic_feeder #(
    parameter int unsigned IMG_W  = 100,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned TMO    = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [6:0]        job_x,
    input  logic [6:0]        job_y,
    input  logic [7:0]        job_tx,
    input  logic [7:0]        job_ty,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              eng_start,
    output logic [7:0]        eng_X0,
    output logic [7:0]        eng_X1,
    output logic [7:0]        eng_X2,
    output logic [7:0]        eng_X3,
    output logic [7:0]        eng_P0,
    output logic [7:0]        eng_P1,
    output logic [7:0]        eng_P2,
    output logic [7:0]        eng_P3,
    input  logic [7:0]        eng_out_val,
    input  logic              eng_finish,
    output logic              res_valid,
    output logic [7:0]        res_data,
    output logic              res_err,
    output logic              busy
);

    localparam int unsigned CRD_W = 7;
    localparam int unsigned PIX_W = 8;
    localparam int unsigned CNT_W = $clog2(TMO + 1);
    // Counter value on the last wait cycle whose decision lands res_valid TMO cycles after eng_start
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POW,
        S_FETCH,
        S_ROW_START,
        S_ROW_WAIT,
        S_COL_START,
        S_COL_WAIT,
        S_OUT
    } state_t;

    state_t state, state_n;

    logic [CRD_W-1:0]      jx, jx_n, jy, jy_n;
    logic [PIX_W-1:0]      tx, tx_n, ty, ty_n;
    logic [PIX_W-1:0]      tx2, tx2_n, tx3, tx3_n, ty2, ty2_n, ty3, ty3_n;
    logic                  pcnt, pcnt_n;
    logic [2:0]            fcnt, fcnt_n;
    logic [1:0]            r, r_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [3:0][PIX_W-1:0] pix, pix_n;
    logic [3:0][PIX_W-1:0] colbuf, colbuf_n;
    logic [3:0][PIX_W-1:0] eng_x, eng_x_n;
    logic [3:0][PIX_W-1:0] eng_p, eng_p_n;
    logic                  mem_rd_en_n;
    logic [ADDR_W-1:0]     mem_addr_n;
    logic                  eng_start_n;
    logic                  res_valid_n;
    logic [PIX_W-1:0]      res_data_n;
    logic                  res_err_n;

    // Q0.8 product with round-half-up
    function automatic logic [PIX_W-1:0] qmul(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b) + 16'd128;
        return p[15:8];
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input logic [CRD_W-1:0] x, input logic [CRD_W-1:0] y,
                                                  input logic [1:0] rr, input logic [2:0] c);
        logic [31:0] a;
        a = (32'(y) + 32'(rr)) * 32'(IMG_W) + 32'(x) + 32'(c);
        return ADDR_W'(a);
    endfunction

    always_comb begin
        state_n     = state;
        jx_n        = jx;
        jy_n        = jy;
        tx_n        = tx;
        ty_n        = ty;
        tx2_n       = tx2;
        tx3_n       = tx3;
        ty2_n       = ty2;
        ty3_n       = ty3;
        pcnt_n      = pcnt;
        fcnt_n      = fcnt;
        r_n         = r;
        cnt_n       = cnt;
        pix_n       = pix;
        colbuf_n    = colbuf;
        eng_x_n     = eng_x;
        eng_p_n     = eng_p;
        mem_rd_en_n = 1'b0;
        mem_addr_n  = mem_addr;
        eng_start_n = 1'b0;
        res_valid_n = 1'b0;
        res_data_n  = res_data;
        res_err_n   = 1'b0;

        case (state)
            S_IDLE: begin
                if (job_valid) begin
                    jx_n    = job_x;
                    jy_n    = job_y;
                    tx_n    = job_tx;
                    ty_n    = job_ty;
                    pcnt_n  = 1'b0;
                    state_n = S_POW;
                end
            end
            S_POW: begin
                if (!pcnt) begin
                    tx2_n  = qmul(tx, tx);
                    ty2_n  = qmul(ty, ty);
                    pcnt_n = 1'b1;
                end else begin
                    tx3_n       = qmul(tx2, tx);
                    ty3_n       = qmul(ty2, ty);
                    r_n         = 2'd0;
                    fcnt_n      = 3'd0;
                    mem_rd_en_n = 1'b1;
                    mem_addr_n  = addr_of(jx, jy, 2'd0, 3'd0);
                    state_n     = S_FETCH;
                end
            end
            S_FETCH: begin
                // Read data trails the strobe by one cycle
                if (fcnt != 3'd0) begin
                    pix_n[2'(fcnt - 3'd1)] = mem_rd_data;
                end
                if (fcnt == 3'd4) begin
                    eng_start_n = 1'b1;
                    eng_x_n     = {tx3, tx2, tx, 8'hFF};
                    eng_p_n     = pix_n;
                    state_n     = S_ROW_START;
                end else begin
                    fcnt_n = fcnt + 3'd1;
                    if (fcnt_n < 3'd4) begin
                        mem_rd_en_n = 1'b1;
                        mem_addr_n  = addr_of(jx, jy, r, fcnt_n);
                    end
                end
            end
            S_ROW_START: begin
                cnt_n   = '0;
                state_n = S_ROW_WAIT;
            end
            S_ROW_WAIT: begin
                if (eng_finish) begin
                    colbuf_n[r] = eng_out_val;
                    if (r == 2'd3) begin
                        eng_start_n = 1'b1;
                        eng_x_n     = {ty3, ty2, ty, 8'hFF};
                        eng_p_n     = colbuf_n;
                        state_n     = S_COL_START;
                    end else begin
                        r_n         = r + 2'd1;
                        fcnt_n      = 3'd0;
                        mem_rd_en_n = 1'b1;
                        mem_addr_n  = addr_of(jx, jy, r_n, 3'd0);
                        state_n     = S_FETCH;
                    end
                end else if (cnt == CNT_LAST) begin
                    res_valid_n = 1'b1;
                    res_err_n   = 1'b1;
                    res_data_n  = '0;
                    state_n     = S_OUT;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_COL_START: begin
                cnt_n   = '0;
                state_n = S_COL_WAIT;
            end
            S_COL_WAIT: begin
                if (eng_finish) begin
                    res_valid_n = 1'b1;
                    res_data_n  = eng_out_val;
                    state_n     = S_OUT;
                end else if (cnt == CNT_LAST) begin
                    res_valid_n = 1'b1;
                    res_err_n   = 1'b1;
                    res_data_n  = '0;
                    state_n     = S_OUT;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_OUT: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            jx        <= '0;
            jy        <= '0;
            tx        <= '0;
            ty        <= '0;
            tx2       <= '0;
            tx3       <= '0;
            ty2       <= '0;
            ty3       <= '0;
            pcnt      <= 1'b0;
            fcnt      <= '0;
            r         <= '0;
            cnt       <= '0;
            pix       <= '0;
            colbuf    <= '0;
            eng_x     <= '0;
            eng_p     <= '0;
            job_ready <= 1'b1;
            busy      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            eng_start <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
        end else begin
            state     <= state_n;
            jx        <= jx_n;
            jy        <= jy_n;
            tx        <= tx_n;
            ty        <= ty_n;
            tx2       <= tx2_n;
            tx3       <= tx3_n;
            ty2       <= ty2_n;
            ty3       <= ty3_n;
            pcnt      <= pcnt_n;
            fcnt      <= fcnt_n;
            r         <= r_n;
            cnt       <= cnt_n;
            pix       <= pix_n;
            colbuf    <= colbuf_n;
            eng_x     <= eng_x_n;
            eng_p     <= eng_p_n;
            job_ready <= (state_n == S_IDLE);
            busy      <= (state_n != S_IDLE);
            mem_rd_en <= mem_rd_en_n;
            mem_addr  <= mem_addr_n;
            eng_start <= eng_start_n;
            res_valid <= res_valid_n;
            res_data  <= res_data_n;
            res_err   <= res_err_n;
        end
    end

    assign eng_X0 = eng_x[0];
    assign eng_X1 = eng_x[1];
    assign eng_X2 = eng_x[2];
    assign eng_X3 = eng_x[3];
    assign eng_P0 = eng_p[0];
    assign eng_P1 = eng_p[1];
    assign eng_P2 = eng_p[2];
    assign eng_P3 = eng_p[3];

endmodule

// File: tb/tb_bicubic_feeder.sv
// Directed + randomized bench for bicubic_feeder with behavioural memory,
// engine and window-result model.
module tb_bicubic_feeder;

    localparam int IMG_W  = 100;
    localparam int ADDR_W = 14;
    localparam int TMO    = 31;

    logic              clk = 1'b0;
    logic              rst;
    logic              job_valid;
    logic              job_ready;
    logic [6:0]        job_x, job_y;
    logic [7:0]        job_tx, job_ty;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic              eng_start;
    logic [7:0]        eng_X0, eng_X1, eng_X2, eng_X3;
    logic [7:0]        eng_P0, eng_P1, eng_P2, eng_P3;
    logic [7:0]        eng_out_val;
    logic              eng_finish;
    logic              res_valid;
    logic [7:0]        res_data;
    logic              res_err;
    logic              busy;

    logic [31:0] ex, ep;
    assign ex = {eng_X3, eng_X2, eng_X1, eng_X0};
    assign ep = {eng_P3, eng_P2, eng_P1, eng_P0};

    bicubic_feeder #(.IMG_W(IMG_W), .ADDR_W(ADDR_W), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_x(job_x), .job_y(job_y), .job_tx(job_tx), .job_ty(job_ty),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .eng_start(eng_start),
        .eng_X0(eng_X0), .eng_X1(eng_X1), .eng_X2(eng_X2), .eng_X3(eng_X3),
        .eng_P0(eng_P0), .eng_P1(eng_P1), .eng_P2(eng_P2), .eng_P3(eng_P3),
        .eng_out_val(eng_out_val), .eng_finish(eng_finish),
        .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
        .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int mem_mode  = 0;
    int eng_mode  = 0;
    int eng_delay = 5;
    bit eng_never = 1'b0;
    bit hang_col  = 1'b0;
    int stray_req = 0;
    int total_starts = 0;
    int job_base     = 0;
    int start_cyc_log [256];
    logic [31:0] x_log [256];
    int addr_total = 0;
    int addr_base  = 0;
    int addr_log [4096];
    int res_count  = 0;
    int idle_viol  = 0;
    logic [31:0] exp_xh, exp_xv, exp_colpix;
    logic [31:0] exp_rowpix [4];
    logic [7:0]  exp_res;
    logic [7:0]  last_res;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] memv(input int a);
        if (mem_mode == 0) return 8'(a);
        return 8'((a * 113 + 71) ^ (a >> 5));
    endfunction

    // Weight powers straight from the Q0.8 definition
    function automatic logic [31:0] xvec(input int t);
        int t2, t3;
        t2 = (t * t + 128) / 256;
        t3 = (t2 * t + 128) / 256;
        return {8'(t3), 8'(t2), 8'(t), 8'hFF};
    endfunction

    function automatic logic [7:0] eng_fn(input logic [31:0] xv, input logic [31:0] pv);
        int s;
        if (eng_mode == 0) return pv[7:0];
        s = int'(pv[7:0]) + 3 * int'(pv[15:8]) + 5 * int'(pv[23:16]) + 7 * int'(pv[31:24])
          + int'(xv[15:8]) + 2 * int'(xv[23:16]) + 3 * int'(xv[31:24]);
        return 8'(s);
    endfunction

    // Memory: answers each strobe on the following cycle
    initial begin
        bit pend_v;
        int pend_a;
        pend_v = 1'b0;
        pend_a = 0;
        mem_rd_data = 8'h00;
        forever begin
            @(negedge clk);
            mem_rd_data = pend_v ? memv(pend_a) : 8'h5A;
            pend_v = mem_rd_en;
            pend_a = int'(mem_addr);
            if (mem_rd_en) begin
                addr_log[addr_total % 4096] = int'(mem_addr);
                addr_total++;
            end
        end
    end

    // Engine: checks operands on start and on finish, answers after eng_delay cycles
    initial begin
        bit pend;
        int left, k, stray_seen;
        logic [31:0] cap_x, cap_p;
        pend = 1'b0; left = 0; stray_seen = 0; cap_x = '0; cap_p = '0;
        eng_finish = 1'b0;
        eng_out_val = 8'h00;
        forever begin
            @(negedge clk);
            eng_finish = 1'b0;
            if (rst) begin
                pend = 1'b0;
                stray_seen = stray_req;
            end else begin
                if (stray_req != stray_seen) begin
                    stray_seen = stray_req;
                    eng_finish = 1'b1;
                    eng_out_val = 8'hA5;
                end
                if (pend) begin
                    left--;
                    if (left == 0) begin
                        pend = 1'b0;
                        chk("hold_X", ex, cap_x);
                        chk("hold_P", ep, cap_p);
                        eng_finish = 1'b1;
                        eng_out_val = eng_fn(cap_x, cap_p);
                    end
                end
                if (eng_start) begin
                    k = total_starts - job_base;
                    start_cyc_log[total_starts % 256] = cyc;
                    x_log[total_starts % 256] = ex;
                    if (k < 4) begin
                        chk($sformatf("row%0d_X", k), ex, exp_xh);
                        chk($sformatf("row%0d_P", k), ep, exp_rowpix[k]);
                    end else if (k == 4) begin
                        chk("col_X", ex, exp_xv);
                        chk("col_P", ep, exp_colpix);
                    end else begin
                        chk("extra_start", 32'(k), 32'd4);
                    end
                    total_starts++;
                    cap_x = ex;
                    cap_p = ep;
                    if (eng_never || (hang_col && k == 4)) begin
                        pend = 1'b0;
                    end else begin
                        pend = 1'b1;
                        left = (eng_delay == 0) ? int'($urandom_range(1, 12)) : eng_delay;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (res_valid) res_count++;
        if (!rst && job_ready && (mem_rd_en || eng_start)) idle_viol++;
        if (!rst && (job_ready === busy)) idle_viol++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic set_expect(input int x, input int y, input int tx, input int ty);
        logic [7:0] rr [4];
        int a;
        exp_xh = xvec(tx);
        exp_xv = xvec(ty);
        for (int row = 0; row < 4; row++) begin
            a = (y + row) * IMG_W + x;
            exp_rowpix[row] = {memv(a + 3), memv(a + 2), memv(a + 1), memv(a)};
            rr[row] = eng_fn(exp_xh, exp_rowpix[row]);
        end
        exp_colpix = {rr[3], rr[2], rr[1], rr[0]};
        exp_res = eng_fn(exp_xv, exp_colpix);
        job_base = total_starts;
        addr_base = addr_total;
    endtask

    task automatic check_reset(input string p);
        chk({p, "_job_ready"}, 32'(job_ready), 32'd1);
        chk({p, "_busy"}, 32'(busy), 32'd0);
        chk({p, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
        chk({p, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({p, "_eng_start"}, 32'(eng_start), 32'd0);
        chk({p, "_eng_X"}, ex, 32'd0);
        chk({p, "_eng_P"}, ep, 32'd0);
        chk({p, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({p, "_res_data"}, 32'(res_data), 32'd0);
        chk({p, "_res_err"}, 32'(res_err), 32'd0);
    endtask

    task automatic run_job(input int x, input int y, input int tx, input int ty, input bit hold,
                           input bit exp_err, input int exp_starts, input bit chk_lat);
        int res_before, res_cyc;
        bit got;
        set_expect(x, y, tx, ty);
        res_before = res_count;
        chk("ready_idle", 32'(job_ready), 32'd1);
        job_valid = 1'b1;
        job_x = 7'(x); job_y = 7'(y); job_tx = 8'(tx); job_ty = 8'(ty);
        @(negedge clk);
        if (!hold) job_valid = 1'b0;
        chk("busy_on_accept", 32'(busy), 32'd1);
        chk("ready_busy", 32'(job_ready), 32'd0);
        got = 1'b0;
        res_cyc = 0;
        for (int k = 0; k < 4000 && !got; k++) begin
            @(negedge clk);
            if (res_valid) begin got = 1'b1; res_cyc = cyc; end
        end
        chk("result_seen", 32'(got), 32'd1);
        job_valid = 1'b0;
        if (got) begin
            chk("res_err", 32'(res_err), 32'(exp_err));
            chk("res_data", 32'(res_data), exp_err ? 32'd0 : 32'(exp_res));
            last_res = res_data;
            if (chk_lat) chk("tmo_latency", 32'(res_cyc - start_cyc_log[job_base % 256]), 32'(TMO));
            @(negedge clk);
            chk("res_one_cycle", 32'(res_valid), 32'd0);
            chk("ready_after", 32'(job_ready), 32'd1);
            chk("busy_after", 32'(busy), 32'd0);
            chk("res_count", 32'(res_count - res_before), 32'd1);
        end
        chk("start_count", 32'(total_starts - job_base), 32'(exp_starts));
        if (!exp_err) begin
            chk("addr_count", 32'(addr_total - addr_base), 32'd16);
            for (int row = 0; row < 4; row++)
                for (int c = 0; c < 4; c++)
                    chk($sformatf("addr_r%0dc%0d", row, c),
                        32'(addr_log[(addr_base + row * 4 + c) % 4096]),
                        32'(((y + row) * IMG_W + x + c) % (1 << ADDR_W)));
        end
    endtask

    initial begin
        int res_before;
        bit got;
        rst = 1'b1;
        job_valid = 1'b0;
        job_x = '0; job_y = '0; job_tx = '0; job_ty = '0;
        last_res = '0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk);

        // Identity memory, engine echoes P0
        run_job(2, 3, 0, 0, 1'b0, 1'b0, 5, 1'b0);
        chk("ident_result", 32'(last_res), 32'h2E);

        // Known fraction powers
        mem_mode = 1; eng_mode = 1;
        run_job(10, 20, 128, 64, 1'b0, 1'b0, 5, 1'b0);
        chk("row_X_const", x_log[job_base % 256], 32'h204080FF);
        chk("col_X_const", x_log[(job_base + 4) % 256], 32'h041040FF);

        // Random windows and engine latencies
        eng_delay = 0;
        for (int i = 0; i < 6; i++)
            run_job(int'($urandom_range(0, 96)), int'($urandom_range(0, 124)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0, 1'b0, 5, 1'b0);

        // Largest coordinates and fractions
        run_job(96, 124, 255, 255, 1'b0, 1'b0, 5, 1'b0);

        // Finish on the last permitted cycle still wins
        eng_delay = TMO - 1;
        run_job(7, 9, 33, 190, 1'b0, 1'b0, 5, 1'b0);

        // One cycle later is a timeout; the late finish lands in OUT and is ignored
        eng_delay = TMO;
        run_job(7, 9, 33, 190, 1'b0, 1'b1, 1, 1'b1);

        // Engine silent
        eng_never = 1'b1;
        run_job(40, 50, 99, 12, 1'b0, 1'b1, 1, 1'b1);
        eng_never = 1'b0;

        // Engine silent only on the column pass
        eng_delay = 3; hang_col = 1'b1;
        run_job(1, 1, 250, 5, 1'b0, 1'b1, 5, 1'b0);
        hang_col = 1'b0;

        // Reset during the second row wait, job_valid held high
        eng_delay = 20;
        @(negedge clk);
        set_expect(5, 7, 77, 200);
        res_before = res_count;
        job_valid = 1'b1;
        job_x = 7'd5; job_y = 7'd7; job_tx = 8'd77; job_ty = 8'd200;
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (total_starts - job_base >= 2) got = 1'b1;
        end
        chk("second_row_start", 32'(got), 32'd1);
        repeat (3) @(negedge clk);
        chk("busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_reset("async");
        job_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("no_result_after_rst", 32'(res_count - res_before), 32'd0);
        chk("idle_after_rst", 32'(job_ready), 32'd1);

        // Stray finish in IDLE
        stray_req++;
        repeat (3) @(negedge clk);
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_res", 32'(res_count - res_before), 32'd0);
        chk("stray_rd", 32'(mem_rd_en), 32'd0);

        eng_delay = 5;
        run_job(20, 40, 200, 30, 1'b1, 1'b0, 5, 1'b0);

        chk("idle_quiet", 32'(idle_viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
